// File: rtl/voice_sched_pkg.sv
// Shared definitions for the synth-core sample sequencer and the tick generator
// that paces it.
package tt6581_pkg;

    localparam int NUM_VOICES      = 3;
    localparam int TIMEOUT_CYC     = 400;
    localparam int SAMPLE_TICK_CYC = 500;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VOICE = 2'd1,
        FILT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // A one-voice build still needs a 1-bit index bus.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voice_sched_if.sv
// Request/done handshakes between the frame sequencer (master) and the shared
// voice datapath / filter (slave), plus the frame-complete strobe.
interface voice_sched_if
    import tt6581_pkg::*;
#(
    parameter int NUM_VOICES = tt6581_pkg::NUM_VOICES
);
    localparam int IDX_W = idx_width(NUM_VOICES);

    logic             voice_req_o;
    logic [IDX_W-1:0] voice_idx_o;
    logic             voice_done_i;
    logic             filt_req_o;
    logic             filt_done_i;
    logic             sample_valid_o;

    modport master (
        output voice_req_o,
        output voice_idx_o,
        output filt_req_o,
        output sample_valid_o,
        input  voice_done_i,
        input  filt_done_i
    );

    modport slave (
        input  voice_req_o,
        input  voice_idx_o,
        input  filt_req_o,
        input  sample_valid_o,
        output voice_done_i,
        output filt_done_i
    );

endinterface

// File: rtl/voice_sched.sv
// Per-sample frame sequencer: one voice datapath pass per voice, one filter
// pass, then a sample_valid strobe; tracks late ticks and aborts hung handshakes.
module voice_sched
    import tt6581_pkg::*;
#(
    parameter int NUM_VOICES  = tt6581_pkg::NUM_VOICES,
    parameter int TIMEOUT_CYC = tt6581_pkg::TIMEOUT_CYC
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 tick_i,
    voice_sched_if.master        bus,
    output logic                 busy_o,
    output logic                 timeout_o,
    output logic [7:0]           overrun_cnt_o
);

    localparam int               IDX_W    = idx_width(NUM_VOICES);
    localparam int               WD_W     = idx_width(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pending_q, pending_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       ovr_q, ovr_d;
    logic             vreq_q, freq_q, valid_q;

    logic tick_ok;
    logic done_ok;

    assign tick_ok = tick_i & en_i;
    assign done_ok = ((state_q == VOICE) & bus.voice_done_i) |
                     ((state_q == FILT)  & bus.filt_done_i);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        wd_d      = '0;
        timeout_d = timeout_q;
        ovr_d     = ovr_q;

        // A tick while busy is held once; any further one is a dropped sample.
        if ((state_q != IDLE) && tick_ok) begin
            if (pending_q) begin
                if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
            end else begin
                pending_d = 1'b1;
            end
        end
        if (!en_i) pending_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick_ok) begin
                    state_d = VOICE;
                    idx_d   = '0;
                end
            end
            VOICE, FILT: begin
                if (done_ok) begin
                    if (state_q == FILT) begin
                        state_d = DONE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = FILT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE: begin
                pending_d = 1'b0;
                idx_d     = '0;
                state_d   = (en_i && (pending_q || tick_i)) ? VOICE : IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Request/strobe flags come straight from flops so done inputs never reach them combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            ovr_q     <= 8'd0;
            vreq_q    <= 1'b0;
            freq_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            ovr_q     <= ovr_d;
            vreq_q    <= (state_d == VOICE);
            freq_q    <= (state_d == FILT);
            valid_q   <= (state_d == DONE);
        end
    end

    assign bus.voice_req_o    = vreq_q;
    assign bus.voice_idx_o    = idx_q;
    assign bus.filt_req_o     = freq_q;
    assign bus.sample_valid_o = valid_q;
    assign busy_o             = (state_q != IDLE);
    assign timeout_o          = timeout_q;
    assign overrun_cnt_o      = ovr_q;

endmodule

// File: tb/tb_voice_sched.sv
// Directed and randomized checks of voice_sched against a frame-progress model.
module tb_voice_sched;

    localparam int NV = 3;
    localparam int TO = 400;

    logic       clk = 1'b0;
    logic       rst, en, tick;
    logic       busy, timeout;
    logic [7:0] ovr;

    int vectors     = 0;
    int miscompares = 0;

    // Model: phase 0 idle, 1..NV voice (phase-1), NV+1 filter, NV+2 frame end.
    int m_phase = 0;
    bit m_pend  = 0;
    int m_wd    = 0;
    bit m_to    = 0;
    int m_ovr   = 0;

    voice_sched_if #(.NUM_VOICES(NV)) bus ();

    voice_sched #(.NUM_VOICES(NV), .TIMEOUT_CYC(TO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .tick_i        (tick),
        .bus           (bus),
        .busy_o        (busy),
        .timeout_o     (timeout),
        .overrun_cnt_o (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit t, input bit vd, input bit fd);
        bit tok, np, got;
        if (r) begin
            m_phase = 0; m_pend = 0; m_wd = 0; m_to = 0; m_ovr = 0;
            return;
        end
        tok = t && e;
        np  = m_pend;
        if (m_phase != 0 && tok) begin
            if (m_pend) begin
                if (m_ovr < 255) m_ovr++;
            end else np = 1;
        end
        if (!e) np = 0;
        if (m_phase == 0) begin
            if (tok) m_phase = 1;
            m_wd = 0;
        end else if (m_phase <= NV + 1) begin
            got = (m_phase <= NV) ? vd : fd;
            if (got) begin
                m_phase++;
                m_wd = 0;
            end else if (m_wd == TO - 1) begin
                m_phase = 0; np = 0; m_to = 1; m_wd = 0;
            end else m_wd++;
        end else begin
            m_phase = (e && (m_pend || t)) ? 1 : 0;
            np = 0;
            m_wd = 0;
        end
        m_pend = np;
    endtask

    task automatic check_all();
        bit ev;
        int ei;
        ev = (m_phase >= 1 && m_phase <= NV);
        ei = ev ? m_phase - 1 : 0;
        chk("m_vreq",  32'(bus.voice_req_o),    32'(ev));
        chk("m_idx",   32'(bus.voice_idx_o),    32'(ei));
        chk("m_freq",  32'(bus.filt_req_o),     32'(m_phase == NV + 1));
        chk("m_valid", 32'(bus.sample_valid_o), 32'(m_phase == NV + 2));
        chk("m_busy",  32'(busy),               32'(m_phase != 0));
        chk("m_tout",  32'(timeout),            32'(m_to));
        chk("m_ovr",   32'(ovr),                32'(m_ovr));
    endtask

    task automatic step(input bit r, input bit e, input bit t, input bit vd, input bit fd);
        rst = r; en = e; tick = t;
        bus.voice_done_i = vd;
        bus.filt_done_i  = fd;
        @(posedge clk);
        model_update(r, e, t, vd, fd);
        #1;
        check_all();
    endtask

    // Datapath responders: answer after the request has been held 'hold' cycles.
    function automatic bit vresp(input int hold);
        return (m_phase >= 1 && m_phase <= NV) && (m_wd >= hold - 1);
    endfunction

    function automatic bit fresp(input int hold);
        return (m_phase == NV + 1) && (m_wd >= hold - 1);
    endfunction

    initial begin
        bit seen_filt, e, r, t, vd, fd;
        int nvalid;
        rst = 1'b1; en = 1'b0; tick = 1'b0;
        bus.voice_done_i = 1'b0;
        bus.filt_done_i  = 1'b0;

        // Reset and one minimum-latency frame
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, k == 1, vresp(1), fresp(1));
            chk("t1_vreq",  32'(bus.voice_req_o),    32'(k <= 3));
            chk("t1_idx",   32'(bus.voice_idx_o),    32'((k <= 3) ? k - 1 : 0));
            chk("t1_freq",  32'(bus.filt_req_o),     32'(k == 4));
            chk("t1_valid", 32'(bus.sample_valid_o), 32'(k == 5));
            chk("t1_busy",  32'(busy),               32'(k <= 5));
        end

        // Five-cycle responders everywhere
        for (int k = 1; k <= 22; k++) begin
            step(0, 1, k == 1, vresp(5), fresp(5));
            chk("t2_vreq",  32'(bus.voice_req_o),    32'(k <= 15));
            chk("t2_valid", 32'(bus.sample_valid_o), 32'(k == 21));
        end

        // Ticks during a stalled frame, then overrun saturation
        for (int k = 1; k <= 250; k++) begin
            t = (k == 1) || (k == 3) || (k == 5) || (k == 7);
            step(0, 1, t, vresp(50), fresp(50));
            if (k == 8) chk("t3_ovr2", 32'(ovr), 32'd2);
        end
        chk("t3_restart", 32'(busy), 32'd1);
        for (int k = 0; k < 300; k++) step(0, 1, 1, vresp(50), fresp(50));
        chk("t3_sat", 32'(ovr), 32'd255);
        for (int k = 0; k < 500; k++) step(0, 1, 0, vresp(1), fresp(1));
        chk("t3_drain", 32'(busy), 32'd0);

        // Watchdog abort on a silent voice datapath
        for (int k = 1; k <= 402; k++) begin
            step(0, 1, k == 1, 0, 0);
            if (k == 400) chk("t4_held", 32'(bus.voice_req_o), 32'd1);
            if (k == 401) begin
                chk("t4_vreq",  32'(bus.voice_req_o),    32'd0);
                chk("t4_tout",  32'(timeout),            32'd1);
                chk("t4_busy",  32'(busy),               32'd0);
                chk("t4_valid", 32'(bus.sample_valid_o), 32'd0);
            end
        end
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, k == 1, vresp(1), fresp(1));
            chk("t4_valid2", 32'(bus.sample_valid_o), 32'(k == 5));
            chk("t4_sticky", 32'(timeout), 32'd1);
        end

        // Disabled ticks, then en_i dropped during the filter pass
        for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 1'($urandom_range(1)), 0, 0);
            chk("t5_idle", 32'(busy), 32'd0);
        end
        chk("t5_ovr0", 32'(ovr), 32'd0);
        seen_filt = 0;
        nvalid = 0;
        for (int k = 1; k <= 30; k++) begin
            if (m_phase == NV + 1) seen_filt = 1;
            t = (k == 1) || ($urandom_range(2) == 0);
            step(0, !seen_filt, t, vresp(3), fresp(3));
            if (bus.sample_valid_o) nvalid++;
        end
        chk("t5_nvalid", 32'(nvalid), 32'd1);
        chk("t5_idle2",  32'(busy),   32'd0);

        // Reset in the middle of the second voice request
        for (int k = 1; k <= 5; k++) step(0, 1, k == 1, vresp(3), fresp(3));
        chk("t6_idx1", 32'(bus.voice_idx_o), 32'd1);
        step(1, 1, 0, 0, 0);
        chk("t6_vreq",  32'(bus.voice_req_o),    32'd0);
        chk("t6_idx",   32'(bus.voice_idx_o),    32'd0);
        chk("t6_freq",  32'(bus.filt_req_o),     32'd0);
        chk("t6_valid", 32'(bus.sample_valid_o), 32'd0);
        chk("t6_busy",  32'(busy),               32'd0);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            chk("t6_stray", 32'(busy), 32'd0);
        end

        // Done arriving exactly at watchdog expiry wins
        for (int k = 1; k <= 804; k++) begin
            step(0, 1, k == 1, vresp((m_phase == 1) ? TO : 1), fresp(TO));
            if (k == 803) chk("t7_valid", 32'(bus.sample_valid_o), 32'd1);
        end
        chk("t7_tout", 32'(timeout), 32'd0);

        // Randomized traffic with stray dones and occasional reset
        for (int k = 0; k < 4000; k++) begin
            r  = ($urandom_range(1499) == 0);
            e  = ($urandom_range(15) != 0);
            t  = ($urandom_range(39) == 0);
            vd = (m_phase >= 1 && m_phase <= NV) ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
            fd = (m_phase == NV + 1) ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
            step(r, e, t, vd, fd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/voice_sched.md
Name: voice_sched

Overview:
- Per-sample frame sequencer for the synth core.
- On each 50 kHz sample tick it issues the shared voice datapath once per voice, in index order, then issues the shared filter once.
- It then pulses sample_valid_o toward the output/PWM stage.
- It also tracks ticks that arrive while busy (pending/overrun) and aborts hung handshakes via a watchdog.

Parameters:
- NUM_VOICES, 3, number of voices time-multiplexed on the voice datapath (>=1).
- TIMEOUT_CYC, 400, max cycles any single request may stay outstanding before abort (< 500, the tick period).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  scheduler enable; low = ticks ignored.
- tick_i  in  1  one-cycle sample tick from the 50 kHz tick generator.
- voice_req_o  out  1  request to the voice datapath; held until done.
- voice_idx_o  out  $clog2(NUM_VOICES) (min 1)  voice selected for the current request.
- voice_done_i  in  1  voice datapath completion; one-cycle pulse.
- filt_req_o  out  1  request to the filter; held until done.
- filt_done_i  in  1  filter completion; one-cycle pulse.
- sample_valid_o  out  1  one-cycle pulse at frame end.
- busy_o  out  1  high when state != IDLE.
- timeout_o  out  1  sticky watchdog flag.
- overrun_cnt_o  out  8  saturating count of dropped ticks.

Behaviour:
- All state and outputs are updated on posedge clk_i.
- rst_i=1 has priority over everything, including mid-frame:
  - state=IDLE, pending=0, voice_idx_o=0, watchdog=0.
  - All req/valid outputs 0, timeout_o=0, overrun_cnt_o=0.
- States: IDLE, VOICE, FILT, DONE.
- IDLE:
  - tick_i&en_i -> VOICE, voice_idx_o=0.
  - Ticks with en_i=0 are discarded and never set pending.
- VOICE:
  - voice_req_o=1.
  - voice_done_i: if idx==NUM_VOICES-1 -> FILT (idx returns to 0); else idx+1, stay in VOICE with req held high, no bubble.
- FILT:
  - filt_req_o=1.
  - filt_done_i -> DONE.
- DONE:
  - sample_valid_o=1 for exactly this cycle.
  - Next state: if pending (or tick_i&en_i this cycle) -> VOICE with idx=0 and pending cleared; else -> IDLE.
- Done inputs arriving in a state that does not expect them are ignored (e.g. voice_done_i in FILT/IDLE, filt_done_i in VOICE).
- Minimum latency, with the datapath answering done in the same cycle as req:
  - tick at cycle T -> voice req at T+1..T+NUM_VOICES.
  - filt req at T+NUM_VOICES+1.
  - sample_valid_o at T+NUM_VOICES+2.
- Tick while busy (state != IDLE, en_i=1), including DONE:
  - pending=0 -> pending=1.
  - pending=1 -> tick dropped, overrun_cnt_o+1, saturating at 255.
- Clearing pending and a new tick in the same DONE cycle: the frame restarts and the tick is treated as dropped only if pending was already 1 before that cycle.
- en_i falling mid-frame: the current frame completes normally; pending is cleared; no new frame starts.
- Watchdog:
  - Counts cycles while in VOICE or FILT.
  - Resets to 0 on every accepted done.
  - At count reaching TIMEOUT_CYC-1 without a done: abort.
- Abort:
  - Next state IDLE, req outputs drop, pending cleared, no sample_valid_o.
  - timeout_o=1 until rst_i.
- A done arriving in the same cycle as expiry wins; no abort occurs.
- Req outputs are registered; no combinational path from done inputs to req outputs.

Decomposition:
- Shared package tt6581_pkg:
  - sched_state_t enum (IDLE, VOICE, FILT, DONE).
  - NUM_VOICES default constant.
  - SAMPLE_TICK_CYC=500 constant shared with the tick generator.
- Single module; no sub-module.
- The watchdog and overrun counters are small enough to stay inline.

Test Plan:
- Reset, then one tick with same-cycle done responders -> voice_req_o high T+1..T+3 with idx 0,1,2; filt_req_o at T+4; sample_valid_o single pulse at T+5; busy_o low at T+6.
- Voice done delayed 5 cycles each -> voice_req_o held continuously, idx advances only on done; sample_valid_o at T+21 (3x5 voice + 5 filter + 1).
- Three ticks during one stalled frame -> first tick sets pending, the next two give overrun_cnt_o=2; the frame restarts immediately after DONE. 300 extra busy ticks -> counter saturates at 255.
- Never assert voice_done_i -> abort after 400 cycles in VOICE; timeout_o=1, req=0, state IDLE, no sample_valid_o; the next tick runs a normal frame while timeout_o stays 1.
- en_i=0 with ticks -> no requests, overrun_cnt_o stays 0. Drop en_i during FILT -> frame completes with one sample_valid_o, then stays idle.
- Assert rst_i in the middle of the second voice request -> next cycle all outputs 0 and idx=0; stray done pulses afterwards are ignored.
